// File: rtl/rr_encoder_if.sv
// ============================================================================
//  Module   : rr_encoder_if
//  Purpose  : Request / grant handshake bundle for the round-robin encoder.
//  Signals  : req       [31:0]  level request vector, bit i = requester i
//             enable            permits new grant loads when high
//             out_ready         consumer accepts the presented address
//             out_valid         encoder holds a live grant
//             out_addr  [4:0]   binary index of the granted requester
//             ack       [31:0]  one-hot acknowledge, only in the accept cycle
//  Modports : master - requester/consumer side (drives req/enable/out_ready)
//             slave  - encoder side (drives out_valid/out_addr/ack)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_encoder_if;
    logic [31:0] req;
    logic        enable;
    logic        out_ready;
    logic        out_valid;
    logic [4:0]  out_addr;
    logic [31:0] ack;

    modport master (
        output req,
        output enable,
        output out_ready,
        input  out_valid,
        input  out_addr,
        input  ack
    );

    modport slave (
        input  req,
        input  enable,
        input  out_ready,
        output out_valid,
        output out_addr,
        output ack
    );
endinterface

`default_nettype wire

// File: rtl/rr_encoder.sv
// ============================================================================
//  Module   : rr_encoder
//  Purpose  : Round-robin priority encoder with a registered, held grant.
//             In IDLE the first set request at or after the rotating
//             pointer is captured into the address register. The grant is
//             held (immune to req/enable changes) until accepted, after
//             which the pointer moves one past the granted index and the
//             block spends one cycle in IDLE before the next grant.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - rr_encoder_if.slave (req, enable, out_ready in;
//                      out_valid, out_addr, ack out)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_encoder (
    input  wire logic    clk,
    input  wire logic    rst_n,
    rr_encoder_if.slave  bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HOLD = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [4:0]  r_addr;
    logic [4:0]  w_addr_nxt;
    logic [4:0]  r_ptr;
    logic [4:0]  w_ptr_nxt;

    logic [31:0] w_rot;
    logic [4:0]  w_off;
    logic [4:0]  w_grant;
    logic        w_any;

    // Rotate the request vector so the pointer position lands at bit 0;
    // the lowest set bit of the rotated vector is then the winner.
    assign w_rot = 32'({bus.req, bus.req} >> r_ptr);

    always_comb begin
        w_off = 5'd0;
        for (int j = 31; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = 5'(j);
            end
        end
    end

    assign w_any   = |bus.req;
    // 5-bit add wraps modulo 32, undoing the rotation.
    assign w_grant = r_ptr + w_off;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 5'd0;
            r_ptr   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (bus.enable && w_any) begin
                    w_state_nxt = S_HOLD;
                    w_addr_nxt  = w_grant;
                end
            end
            S_HOLD: begin
                // Held grant ignores req and enable; only acceptance
                // releases it. Returning to IDLE gives the mandatory gap.
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = r_addr + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        bus.out_valid = (r_state == S_HOLD);
        bus.out_addr  = r_addr;
        bus.ack       = 32'h0;
        if ((r_state == S_HOLD) && bus.out_ready) begin
            bus.ack = 32'd1 << r_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_encoder.sv
// ============================================================================
//  Module   : tb_rr_encoder
//  Purpose  : Self-checking bench for rr_encoder with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_encoder_if bus();

    rr_encoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit m_valid;
    int m_addr;
    int m_ptr;

    function automatic int first_set(input logic [31:0] r, input int p);
        for (int k = 0; k < 32; k++) begin
            if (r[(p + k) % 32]) return (p + k) % 32;
        end
        return 0;
    endfunction

    function automatic logic [31:0] exp_ack();
        logic [31:0] a;
        a = 32'h0;
        if (m_valid && bus.out_ready) a[m_addr] = 1'b1;
        return a;
    endfunction

    // Drive inputs in the low clock phase, settle before checks.
    task automatic apply(input logic [31:0] r, input logic e, input logic rdy);
        bus.req       = r;
        bus.enable    = e;
        bus.out_ready = rdy;
        #1;
    endtask

    // Advance one clock and move the model by the same rules.
    task automatic tick();
        @(posedge clk);
        if (m_valid) begin
            if (bus.out_ready) begin
                m_valid = 1'b0;
                m_ptr   = (m_addr + 1) % 32;
            end
        end else if (bus.enable && (bus.req != 32'h0)) begin
            m_valid = 1'b1;
            m_addr  = first_set(bus.req, m_ptr);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = 0;
        m_ptr   = 0;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req       = 32'h0;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req       = 32'hFFFF_FFFF;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        n_checks++;
        if (bus.out_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr got=%0d exp=0", bus.out_addr); end
        n_checks++;
        if (bus.ack !== 32'h0) begin n_fail++; $display("FAIL reset_ack got=%h exp=0", bus.ack); end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid got=%b exp=0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        apply(32'h2, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", bus.out_valid); end
        tick();
        apply(32'h2, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd1)
            begin n_fail++; $display("FAIL single_grant valid=%b addr=%0d exp valid=1 addr=1", bus.out_valid, bus.out_addr); end
        n_checks++;
        if (bus.ack !== 32'h2) begin n_fail++; $display("FAIL single_ack got=%h exp=00000002", bus.ack); end
        tick();
        apply(32'h2, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.ack !== 32'h0)
            begin n_fail++; $display("FAIL single_gap valid=%b ack=%h exp valid=0 ack=0", bus.out_valid, bus.ack); end
        tick();
    endtask

    // Fixed request pattern from reset; compares accepted addresses
    // against an explicit expected sequence.
    task automatic run_sequence(input string name, input logic [31:0] r,
                                input int cycles, input int exp_q[$]);
        int got_q[$];
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            apply(r, 1'b1, 1'b1);
            n_checks++;
            if (bus.out_valid !== m_valid || bus.ack !== exp_ack())
                begin n_fail++; $display("FAIL %s_cyc%0d valid=%b ack=%h exp valid=%b ack=%h", name, c, bus.out_valid, bus.ack, m_valid, exp_ack()); end
            if (bus.ack !== 32'h0) got_q.push_back(int'(bus.out_addr));
            tick();
        end
        n_checks++;
        if (got_q.size() != exp_q.size())
            begin n_fail++; $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), exp_q.size()); end
        else
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] != exp_q[i])
                    begin n_fail++; $display("FAIL %s_grant%0d got=%0d exp=%0d", name, i, got_q[i], exp_q[i]); end
            end
    endtask

    task automatic test_pair();
        run_sequence("pair", 32'h0000_0401, 8, '{0, 10, 0, 10});
    endtask

    task automatic test_wrap();
        run_sequence("wrap", 32'h8000_0001, 6, '{0, 31, 0});
    endtask

    task automatic test_all_ones();
        int exp_q[$];
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        exp_q.push_back(0);
        run_sequence("allones", 32'hFFFF_FFFF, 66, exp_q);
    endtask

    task automatic test_backpressure();
        do_reset();
        apply(32'h20, 1'b1, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            apply(32'h8000, c[0], 1'b0);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd5 || bus.ack !== 32'h0)
                begin n_fail++; $display("FAIL bp_hold%0d valid=%b addr=%0d ack=%h exp 1/5/0", c, bus.out_valid, bus.out_addr, bus.ack); end
            tick();
        end
        apply(32'h8000, 1'b1, 1'b1);
        n_checks++;
        if (bus.ack !== 32'h20) begin n_fail++; $display("FAIL bp_ack got=%h exp=00000020", bus.ack); end
        tick();
        apply(32'h8000, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap got=%b exp=0", bus.out_valid); end
        tick();
        apply(32'h8000, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd15)
            begin n_fail++; $display("FAIL bp_next valid=%b addr=%0d exp 1/15", bus.out_valid, bus.out_addr); end
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            apply(32'hFFFF_FFFF, 1'b0, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.ack !== 32'h0)
                begin n_fail++; $display("FAIL en_off%0d valid=%b ack=%h exp 0/0", c, bus.out_valid, bus.ack); end
            tick();
        end
        apply(32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        apply(32'hFFFF_FFFF, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd0 || bus.ack !== 32'h1)
            begin n_fail++; $display("FAIL en_on valid=%b addr=%0d ack=%h exp 1/0/00000001", bus.out_valid, bus.out_addr, bus.ack); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        apply(32'h400, 1'b1, 1'b0);
        tick();
        apply(32'h400, 1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd10)
            begin n_fail++; $display("FAIL rmh_pre valid=%b addr=%0d exp 1/10", bus.out_valid, bus.out_addr); end
        #2;
        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 5'd0 || bus.ack !== 32'h0)
            begin n_fail++; $display("FAIL rmh_async valid=%b addr=%0d ack=%h exp 0/0/0", bus.out_valid, bus.out_addr, bus.ack); end
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h400, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmh_idle got=%b exp=0", bus.out_valid); end
        tick();
        apply(32'h400, 1'b1, 1'b1);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 5'd10 || bus.ack !== 32'h400)
            begin n_fail++; $display("FAIL rmh_regrant valid=%b addr=%0d ack=%h exp 1/10/00000400", bus.out_valid, bus.out_addr, bus.ack); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        e;
        logic        rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0: r = $urandom();
                1: r = 32'd1 << $urandom_range(0, 31);
                2: r = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
                default: r = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom() & $urandom());
            endcase
            e   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            apply(r, e, rdy);
            n_checks++;
            if (bus.out_valid !== m_valid)
                begin n_fail++; $display("FAIL rand_valid%0d got=%b exp=%b", c, bus.out_valid, m_valid); end
            n_checks++;
            if (m_valid && (bus.out_addr !== 5'(m_addr)))
                begin n_fail++; $display("FAIL rand_addr%0d got=%0d exp=%0d", c, bus.out_addr, m_addr); end
            n_checks++;
            if (bus.ack !== exp_ack())
                begin n_fail++; $display("FAIL rand_ack%0d got=%h exp=%h", c, bus.ack, exp_ack()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_wrap();
        test_all_ones();
        test_backpressure();
        test_enable();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
